// File: rtl/vga_fb_arbiter.sv
// ============================================================================
// vga_fb_arbiter: shares a 1-cycle-latency frame RAM between VGA scan-out
// (absolute priority) and a host req/ack port. Option: VGA_ARB_VBLANK_ONLY_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              hs,
  input  logic              vs,
  output logic              hs_out,
  output logic              vs_out,
  output logic [DATA_W-1:0] pix_color,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata
);

  localparam logic [9:0]        C_X_ACT   = 10'(4 * FB_W);
  localparam logic [9:0]        C_Y_ACT   = 10'(4 * FB_H);
  localparam logic [ADDR_W-1:0] C_FB_W    = ADDR_W'(FB_W);
  // One extra bit so a full-size framebuffer (FB_W*FB_H == 2^ADDR_W) compares correctly
  localparam logic [ADDR_W:0]   C_FB_SIZE = (ADDR_W + 1)'(FB_W * FB_H);

  logic              active;
  logic              disp_slot;
  logic              host_slot;
  logic              addr_oor;
  logic [ADDR_W-1:0] disp_addr;

  logic              hs_d1_q, hs_d1_d, hs_d2_q, hs_d2_d;
  logic              vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
  logic              act_d1_q, act_d1_d, act_d2_q, act_d2_d;
  logic              disp_d1_q, disp_d1_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_oor_q, rd_oor_d;

  always_comb begin
    active    = (hpos < C_X_ACT) && (vpos < C_Y_ACT);
    disp_slot = active && (hpos[1:0] == 2'b00);
`ifdef VGA_ARB_VBLANK_ONLY_EN
    host_slot = (vpos >= C_Y_ACT);
`else
    host_slot = !disp_slot;
`endif
    cpu_ack   = host_slot && cpu_req;
    addr_oor  = {1'b0, cpu_addr} >= C_FB_SIZE;
    disp_addr = ADDR_W'(ADDR_W'(vpos[9:2]) * C_FB_W) + ADDR_W'(hpos[9:2]);

    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (disp_slot) begin
      mem_addr = disp_addr;
    end else if (cpu_ack) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we && !addr_oor;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    hs_d1_d   = hs;
    hs_d2_d   = hs_d1_q;
    vs_d1_d   = vs;
    vs_d2_d   = vs_d1_q;
    act_d1_d  = active;
    act_d2_d  = act_d1_q;
    disp_d1_d = disp_slot;
    // RAM data for a display slot arrives one cycle later
    pix_d     = disp_d1_q ? mem_rdata : pix_q;
    rd_pend_d = cpu_ack && !cpu_we;
    rd_oor_d  = addr_oor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d1_q   <= 1'b0;
      hs_d2_q   <= 1'b0;
      vs_d1_q   <= 1'b0;
      vs_d2_q   <= 1'b0;
      act_d1_q  <= 1'b0;
      act_d2_q  <= 1'b0;
      disp_d1_q <= 1'b0;
      pix_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_oor_q  <= 1'b0;
    end else begin
      hs_d1_q   <= hs_d1_d;
      hs_d2_q   <= hs_d2_d;
      vs_d1_q   <= vs_d1_d;
      vs_d2_q   <= vs_d2_d;
      act_d1_q  <= act_d1_d;
      act_d2_q  <= act_d2_d;
      disp_d1_q <= disp_d1_d;
      pix_q     <= pix_d;
      rd_pend_q <= rd_pend_d;
      rd_oor_q  <= rd_oor_d;
    end
  end

  always_comb begin
    hs_out     = hs_d2_q;
    vs_out     = vs_d2_q;
    pix_color  = act_d2_q ? pix_q : '0;
    cpu_rvalid = rd_pend_q;
    cpu_rdata  = (rd_pend_q && !rd_oor_q) ? mem_rdata : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// ============================================================================
// tb_vga_fb_arbiter: directed self-checking bench with a 1-cycle frame RAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        hs, vs;
  logic        hs_out, vs_out;
  logic [7:0]  pix_color;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack, cpu_rvalid;
  logic [7:0]  cpu_rdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] mem [0:32767];

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .hs(hs), .vs(vs),
    .hs_out(hs_out), .vs_out(vs_out), .pix_color(pix_color),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata)
  );

  // Frame RAM model; preloaded while reset is held
  always @(posedge clk) begin
    if (reset) begin
      mem[161]   <= 8'hA5;
      mem[162]   <= 8'h5A;
      mem[5]     <= 8'h3C;
      mem[19200] <= 8'hEE;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; hpos = 10'd700; vpos = 10'd0; hs = 1'b1; vs = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    adv(); adv(); adv();
    @(negedge clk);
    chk_cnt++;
    if ({hs_out, vs_out, cpu_rvalid, cpu_ack, mem_we} !== 5'b0)
      $display("FAIL reset_ctl: got %b expected 00000", {hs_out, vs_out, cpu_rvalid, cpu_ack, mem_we});
    else pass_cnt++;
    chk_cnt++;
    if ({pix_color, cpu_rdata} !== 16'h0)
      $display("FAIL reset_data: got pix=%h rdata=%h expected 0", pix_color, cpu_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (mem_addr !== 15'd0) $display("FAIL idle_addr: got %0d expected 0", mem_addr);
    else pass_cnt++;
    reset = 1'b0; hs = 1'b0; vs = 1'b0;
    adv();
  endtask

  task automatic test_pixel;
    logic       hs_e, vs_e;
    logic [7:0] pix_e;
    vpos = 10'd4; hpos = 10'd700; hs = 1'b0; vs = 1'b0;
    adv(); adv();
    for (int k = 0; k < 10; k++) begin
      hpos = 10'(4 + k);
      hs   = (k == 0) || (k == 3);
      vs   = (k == 1) || (k == 4) || (k == 5);
      @(negedge clk);
      if (k == 0) begin
        chk_cnt++;
        if (mem_addr !== 15'd161 || mem_we !== 1'b0)
          $display("FAIL disp_addr0: got addr=%0d we=%b expected 161 0", mem_addr, mem_we);
        else pass_cnt++;
      end
      if (k == 4) begin
        chk_cnt++;
        if (mem_addr !== 15'd162) $display("FAIL disp_addr1: got %0d expected 162", mem_addr);
        else pass_cnt++;
      end
      pix_e = (k < 2) ? 8'h00 : (k < 6) ? 8'hA5 : 8'h5A;
      chk_cnt++;
      if (pix_color !== pix_e) $display("FAIL pix k=%0d: got %h expected %h", k, pix_color, pix_e);
      else pass_cnt++;
      if (k >= 2) begin
        hs_e = (k == 2) || (k == 5);
        vs_e = (k == 3) || (k == 6) || (k == 7);
        chk_cnt++;
        if (hs_out !== hs_e || vs_out !== vs_e)
          $display("FAIL sync k=%0d: got hs=%b vs=%b expected hs=%b vs=%b", k, hs_out, vs_out, hs_e, vs_e);
        else pass_cnt++;
      end
      adv();
    end
    hs = 1'b0; vs = 1'b0;
  endtask

  task automatic test_collision;
    vpos = 10'd4; hpos = 10'd8;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd300; cpu_wdata = 8'h77;
    @(negedge clk);
    chk_cnt++;
    if (cpu_ack !== 1'b0 || mem_addr !== 15'd162)
      $display("FAIL collide_slot: got ack=%b addr=%0d expected 0 162", cpu_ack, mem_addr);
    else pass_cnt++;
    adv();
    hpos = 10'd9;
    @(negedge clk);
    chk_cnt++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd300 || mem_wdata !== 8'h77)
      $display("FAIL collide_grant: got ack=%b we=%b addr=%0d wd=%h expected 1 1 300 77",
               cpu_ack, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    adv();
    cpu_req = 1'b0; hpos = 10'd10;
    @(negedge clk);
    chk_cnt++;
    if (mem[300] !== 8'h77 || cpu_ack !== 1'b0)
      $display("FAIL collide_commit: got mem=%h ack=%b expected 77 0", mem[300], cpu_ack);
    else pass_cnt++;
    adv();
  endtask

  task automatic test_back_to_back;
    logic ack_e, rv_e;
    vpos = 10'd4; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd161;
    for (int k = 0; k < 5; k++) begin
      hpos = 10'(12 + k);
      if (k == 4) cpu_req = 1'b0;
      ack_e = (k >= 1) && (k <= 3);
      rv_e  = (k >= 2);
      @(negedge clk);
      chk_cnt++;
      if (cpu_ack !== ack_e || cpu_rvalid !== rv_e || (rv_e && cpu_rdata !== 8'hA5))
        $display("FAIL b2b k=%0d: got ack=%b rv=%b rd=%h expected %b %b a5",
                 k, cpu_ack, cpu_rvalid, cpu_rdata, ack_e, rv_e);
      else pass_cnt++;
      adv();
    end
  endtask

  task automatic test_blank_read;
    vpos = 10'd490; hpos = 10'd0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd5;
    @(negedge clk);
    chk_cnt++;
    if (cpu_ack !== 1'b1 || mem_addr !== 15'd5 || mem_we !== 1'b0)
      $display("FAIL blank_ack: got ack=%b addr=%0d we=%b expected 1 5 0", cpu_ack, mem_addr, mem_we);
    else pass_cnt++;
    adv();
    cpu_req = 1'b0; hpos = 10'd1;
    @(negedge clk);
    chk_cnt++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h3C)
      $display("FAIL blank_rdata: got rv=%b rd=%h expected 1 3c", cpu_rvalid, cpu_rdata);
    else pass_cnt++;
    adv();
    hpos = 10'd2;
    @(negedge clk);
    chk_cnt++;
    if (cpu_rvalid !== 1'b0) $display("FAIL blank_rv_pulse: got %b expected 0", cpu_rvalid);
    else pass_cnt++;
    adv();
  endtask

  task automatic test_out_of_range;
    vpos = 10'd490; hpos = 10'd10;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd19200; cpu_wdata = 8'hFF;
    @(negedge clk);
    chk_cnt++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL oor_write: got ack=%b we=%b expected 1 0", cpu_ack, mem_we);
    else pass_cnt++;
    adv();
    cpu_we = 1'b0; hpos = 10'd11;
    @(negedge clk);
    chk_cnt++;
    if (cpu_ack !== 1'b1) $display("FAIL oor_read_ack: got %b expected 1", cpu_ack);
    else pass_cnt++;
    adv();
    cpu_req = 1'b0; hpos = 10'd12;
    @(negedge clk);
    chk_cnt++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h00 || mem[19200] !== 8'hEE)
      $display("FAIL oor_read: got rv=%b rd=%h mem=%h expected 1 00 ee", cpu_rvalid, cpu_rdata, mem[19200]);
    else pass_cnt++;
    adv();
  endtask

  task automatic test_reset_mid_read;
    vpos = 10'd4; hpos = 10'd4; hs = 1'b0;
    adv();
    hpos = 10'd5; hs = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd5;
    @(negedge clk);
`ifndef VGA_ARB_VBLANK_ONLY_EN
    chk_cnt++;
    if (cpu_ack !== 1'b1) $display("FAIL midrd_ack: got %b expected 1", cpu_ack);
    else pass_cnt++;
`endif
    adv();
    hpos = 10'd6; hs = 1'b0; cpu_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (pix_color !== 8'hA5) $display("FAIL midrd_pix_pre: got %h expected a5", pix_color);
    else pass_cnt++;
    adv();
    hpos = 10'd7; reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (cpu_rvalid !== 1'b0 || pix_color !== 8'h00 || hs_out !== 1'b0 || cpu_rdata !== 8'h00)
      $display("FAIL midrd_reset: got rv=%b pix=%h hs=%b rd=%h expected 0 00 0 00",
               cpu_rvalid, pix_color, hs_out, cpu_rdata);
    else pass_cnt++;
    adv();
  endtask

  task automatic test_vblank_mode;
    logic ack_e;
`ifdef VGA_ARB_VBLANK_ONLY_EN
    ack_e = 1'b0;
`else
    ack_e = 1'b1;
`endif
    vpos = 10'd10; hpos = 10'd1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd5;
    @(negedge clk);
    chk_cnt++;
    if (cpu_ack !== ack_e) $display("FAIL visible_req: got %b expected %b", cpu_ack, ack_e);
    else pass_cnt++;
    adv();
    hpos = 10'd4;
    @(negedge clk);
    chk_cnt++;
    if (cpu_ack !== 1'b0) $display("FAIL visible_disp_slot: got %b expected 0", cpu_ack);
    else pass_cnt++;
    adv();
    vpos = 10'd480; hpos = 10'd0;
    @(negedge clk);
    chk_cnt++;
    if (cpu_ack !== 1'b1) $display("FAIL vblank_ack: got %b expected 1", cpu_ack);
    else pass_cnt++;
    adv();
    cpu_req = 1'b0;
    adv();
  endtask

  initial begin
    test_reset();
    test_pixel();
`ifndef VGA_ARB_VBLANK_ONLY_EN
    test_collision();
    test_back_to_back();
`endif
    test_blank_read();
    test_out_of_range();
    test_reset_mid_read();
    test_vblank_mode();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
